// File: rtl/led_fader.sv
// PWM LED output stage: holds one pending pattern, applies it at frame ends,
// drives lit LEDs full-on and lets dropped LEDs fade out linearly.
module led_fader #(
  parameter int unsigned N_LEDS       = 5,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned DECAY_FRAMES = 64,
  parameter int unsigned DECAY_STEP   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pat_valid_i,
  input  logic [N_LEDS-1:0] pat_i,
  output logic              pat_ready_o,
  output logic [N_LEDS-1:0] led_o
);

  localparam int unsigned LW  = PWM_BITS;
  localparam int unsigned LW1 = PWM_BITS + 1;
  localparam int unsigned FW  = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  localparam logic [LW-1:0] LVL_MAX    = '1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(DECAY_FRAMES - 1);
  localparam logic [LW1-1:0] STEP      = LW1'(DECAY_STEP);

  logic [LW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [N_LEDS-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [N_LEDS-1:0] cur_q, cur_d;
  logic [LW-1:0]     level_q [N_LEDS];
  logic [LW-1:0]     level_d [N_LEDS];
  logic [N_LEDS-1:0] led_q, led_d;

  logic              frame_end;
  logic              decay_tick;
  logic              apply;
  logic              accept;
  logic [N_LEDS-1:0] eff_pat;
  logic [LW1-1:0]    level_ext;

  assign pat_ready_o = !pend_v_q && !reset_i;
  assign led_o       = led_q;

  // Frame timing, handshake, level update and PWM compare.
  always_comb begin
    frame_end   = (pwm_cnt_q == LVL_MAX);
    decay_tick  = frame_end && (frame_cnt_q == FRAME_LAST);
    apply       = frame_end && pend_v_q;
    accept      = pat_valid_i && pat_ready_o;
    eff_pat     = apply ? pend_q : cur_q;

    pwm_cnt_d   = pwm_cnt_q + LW'(1);
    frame_cnt_d = frame_cnt_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    cur_d       = cur_q;
    led_d       = '0;
    level_ext   = '0;
    for (int i = 0; i < N_LEDS; i++) level_d[i] = level_q[i];

    if (frame_end) frame_cnt_d = decay_tick ? '0 : frame_cnt_q + FW'(1);

    // Acceptance and apply are mutually exclusive: ready is low while pending.
    if (apply) begin
      cur_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pend_d   = pat_i;
      pend_v_d = 1'b1;
    end

    for (int i = 0; i < N_LEDS; i++) begin
      level_ext = {1'b0, level_q[i]};
      if (frame_end) begin
        if (eff_pat[i]) begin
          level_d[i] = LVL_MAX;
        end else if (decay_tick) begin
          level_d[i] = (level_ext < STEP) ? '0 : LW'(level_ext - STEP);
        end
      end
      led_d[i] = (level_q[i] == LVL_MAX) || (pwm_cnt_q < level_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pwm_cnt_q   <= '0;
      frame_cnt_q <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      cur_q       <= '0;
      led_q       <= '0;
      for (int i = 0; i < N_LEDS; i++) level_q[i] <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      cur_q       <= cur_d;
      led_q       <= led_d;
      for (int i = 0; i < N_LEDS; i++) level_q[i] <= level_d[i];
    end
  end

endmodule
